// File: rtl/reduce_mux_burst.sv
// reduce_mux_burst
//   Reduces GROUPS input groups of GROUP_W bits each. Each group has its own
//   gate (NAND/NOR/XOR/AND). The block has two registered output paths:
//   - manual path: G_Q carries every group result, and MUX_Q carries the
//     result of group SEL. Both update every cycle.
//   - burst path: START (in IDLE) snapshots all group results. The snapshot
//     then streams out one beat per accepted O_VALID/O_READY handshake.
//
// Ports
//   CLK      rising-edge clock
//   RST_N    synchronous active-low reset
//   IN       group k at IN[k*GROUP_W +: GROUP_W]
//   OP       gate for group k at OP[2k +: 2]: 00 NAND, 01 NOR, 10 XOR, 11 AND
//   SEL      manual-path group select (out-of-range selects give 0)
//   START    burst request, honoured only in IDLE
//   O_READY  downstream accepts the current beat
//   G_Q      registered result of every group
//   MUX_Q    registered result of group SEL
//   O_VALID  burst beat valid
//   O_DATA   snapshot result of group O_IDX
//   O_IDX    index of the current beat
//   O_LAST   final beat marker
//   BUSY     burst in progress
module reduce_mux_burst #(
  parameter  int GROUPS  = 2,
  parameter  int GROUP_W = 3,
  localparam int IW      = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [GROUPS*GROUP_W-1:0]  IN,
  input  logic [2*GROUPS-1:0]        OP,
  input  logic [IW-1:0]              SEL,
  input  logic                       START,
  input  logic                       O_READY,
  output logic [GROUPS-1:0]          G_Q,
  output logic                       MUX_Q,
  output logic                       O_VALID,
  output logic                       O_DATA,
  output logic [IW-1:0]              O_IDX,
  output logic                       O_LAST,
  output logic                       BUSY
);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e            state_q, state_d;
  logic [GROUPS-1:0] r;
  logic [GROUPS-1:0] g_q;
  logic              mux_q, mux_d;
  logic [GROUPS-1:0] snap_q, snap_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              beat_last;
  logic              beat_data;

  // Per-group reduction
  always_comb begin
    r = '0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      case (OP[2*k +: 2])
        2'b00:   r[k] = ~(&IN[k*GROUP_W +: GROUP_W]);
        2'b01:   r[k] = ~(|IN[k*GROUP_W +: GROUP_W]);
        2'b10:   r[k] = ^IN[k*GROUP_W +: GROUP_W];
        default: r[k] = &IN[k*GROUP_W +: GROUP_W];
      endcase
    end
  end

  // Select by equality compare: SEL values >= GROUPS match no group and give 0
  always_comb begin
    mux_d = 1'b0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      if (SEL == IW'(k)) mux_d = r[k];
    end
  end

  always_comb begin
    beat_data = 1'b0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      if (idx_q == IW'(k)) beat_data = snap_q[k];
    end
  end

  assign beat_last = (idx_q == IW'(GROUPS - 1));

  // Burst FSM next state
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          snap_d  = r;
          idx_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (O_READY) begin
          if (beat_last) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      g_q     <= '0;
      mux_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      g_q     <= r;
      mux_q   <= mux_d;
    end
  end

  // Beat outputs come from registers only and are forced to 0 outside a burst
  assign G_Q     = g_q;
  assign MUX_Q   = mux_q;
  assign O_VALID = (state_q == S_BURST);
  assign BUSY    = (state_q == S_BURST);
  assign O_DATA  = O_VALID & beat_data;
  assign O_IDX   = O_VALID ? idx_q : '0;
  assign O_LAST  = O_VALID & beat_last;

endmodule

// File: doc/reduce_mux_burst.md
# reduce_mux_burst

Parametrised successor to the team's fixed two-group NAND/NOR-plus-2:1-mux lab block. It reduces GROUPS independent input groups with a per-group selectable gate (NAND/NOR/XOR/AND) and offers two registered output paths. The manual path selects one group result through SEL every cycle. The burst path snapshots all groups on START and streams the results out one per beat over a valid/ready handshake. It sits between the lab switch/button inputs and downstream LED/display or serial logic.

## Interface
- GROUPS, default 2: number of input groups; legal range 1..16.
- GROUP_W, default 3: bits per group; legal range 1..16.
- IW (localparam): equals $clog2(GROUPS) when GROUPS>1, else 1.
- CLK  in  1  single clock; all state updates on its rising edge.
- RST_N  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- IN  in  GROUPS*GROUP_W  group k occupies bits IN[k*GROUP_W +: GROUP_W].
- OP  in  2*GROUPS  gate select for group k at OP[2k +: 2]: 00=NAND, 01=NOR, 10=XOR, 11=AND.
- SEL  in  IW  manual-path group select.
- START  in  1  burst request; sampled only in IDLE.
- O_READY  in  1  downstream accepts the current beat.
- G_Q  out  GROUPS  registered live result of every group; bit k is group k.
- MUX_Q  out  1  registered live result of group SEL.
- O_VALID  out  1  burst beat valid.
- O_DATA  out  1  burst beat value: snapshot result of group O_IDX.
- O_IDX  out  IW  group index of the current beat.
- O_LAST  out  1  high with the final beat (O_IDX == GROUPS-1).
- BUSY  out  1  high while the state is BURST.

## Operation
- Reduction, for each group k: r[k] = op(IN group k).
  - NAND = ~&g; NOR = ~|g; XOR = ^g; AND = &g.
  - With GROUP_W=1: NAND and NOR give ~g; XOR and AND give g.
- Manual path, updated every cycle regardless of state:
  - G_Q <= r.
  - MUX_Q <= r[SEL] when SEL < GROUPS, else 0.
- Burst path FSM, states IDLE and BURST:
  - IDLE, START=1: capture snap <= r from the current IN/OP, set idx <= 0, go to BURST.
  - IDLE, START=0: stay in IDLE.
  - BURST: O_VALID=1, O_DATA=snap[idx], O_IDX=idx, O_LAST=(idx==GROUPS-1).
  - BURST, O_VALID & O_READY with idx<GROUPS-1: idx <= idx+1.
  - BURST, O_VALID & O_READY with idx==GROUPS-1: go to IDLE; O_VALID drops the next cycle.
  - BURST, O_READY=0: hold idx and all beat outputs stable.
- While in BURST, changes on START, IN and OP do not affect snap or the beat outputs.
- GROUPS=1: each burst is a single beat with O_IDX=0 and O_LAST=1.

## Timing
- Reset values (RST_N=0 at an edge): G_Q=0, MUX_Q=0, O_VALID=0, O_DATA=0, O_IDX=0, O_LAST=0, BUSY=0; state=IDLE; snap=0.
- Reset mid-burst: the burst is aborted with no further beats; the first START is honoured on the first edge with RST_N=1.
- Manual path latency: 1 cycle from IN/OP/SEL to G_Q/MUX_Q. No combinational path from any input to any output.
- Burst start: START sampled high in IDLE at edge k gives BUSY=1, O_VALID=1, O_IDX=0 after edge k.
- Burst throughput: with O_READY held high, beats are presented after edges k..k+GROUPS-1. The final beat is accepted at edge k+GROUPS; O_VALID and BUSY are 0 after that edge.
- Burst restart: the earliest next START is sampled at edge k+GROUPS+1, because the FSM must be in IDLE. There is no back-to-back burst.
- Outputs between bursts: O_DATA, O_IDX and O_LAST return to 0 whenever O_VALID=0.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with IN all ones and START=1 -> every output is 0 and BUSY=0. After release, START is taken on the next edge.
- Manual path (GROUPS=2, GROUP_W=3):
  - Stimulus: OP=4'b0100, IN=6'b000_111.
  - One cycle later: G_Q=2'b10. With SEL=1, MUX_Q=1; with SEL=0, MUX_Q=0 one cycle after the change.
- Full burst (GROUPS=4, GROUP_W=2):
  - Stimulus: OP=8'hAA (all XOR), IN=8'b11_10_01_00, O_READY=1, START pulse.
  - Response: four consecutive beats with O_DATA=0,1,1,0 and O_IDX=0..3; O_LAST only on index 3; BUSY low after the 4th accept.
- Backpressure and snapshot:
  - Stimulus: same burst, drop O_READY for 3 cycles while O_IDX=1, and flip IN to all ones during the stall.
  - Response: O_VALID=1 with O_IDX=1 and O_DATA=1 held stable for the stall; the remaining beats still read 1,0.
- Ignored START and mid-burst reset:
  - Stimulus: pulse START at O_IDX=2, then assert RST_N=0 at O_IDX=2.
  - Response: START has no effect on the burst; after the reset edge O_VALID=0 and BUSY=0; a new START produces a burst starting at O_IDX=0.
- Edge configuration (GROUPS=1, GROUP_W=1):
  - Stimulus: OP=2'b00, IN=0, START pulse.
  - Response: a single beat with O_DATA=1, O_IDX=0, O_LAST=1.
  - Also: MUX_Q=0 whenever SEL exceeds GROUPS-1, checked in a GROUPS=3 run with SEL=3.
